// File: rtl/rom_dl_router.sv
// rom_dl_router: routes hps_io ioctl download bytes to SDRAM ports, block RAM and DIP switches
// Ports: clk_sys, reset_n (synchronous, active-low); ioctl_* download stream in, ioctl_wait back-pressure out;
//   port1_* CPU words to SDRAM port1 and port2_* remapped sprite bytes to SDRAM port2 (toggle req/ack);
//   dl_* one-cycle block RAM byte writes; dip_sw captured DIP bytes; rom_loaded sticky end-of-ROM flag.
// Macro ROM_DL_CHECKSUM_EN adds rom_sum / rom_sum_valid (16-bit sum of the ROM bytes of the last download).
module rom_dl_router #(
    parameter logic [24:0] SP_BASE  = 25'h10000,
    parameter logic [24:0] SP_END   = 25'h1BFFF,
    parameter logic [24:0] CPU_END  = 25'h09FFF,
    parameter logic [24:0] BRAM_END = 25'h1C31F
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic [63:0] dip_sw,
    output logic        rom_loaded
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0] rom_sum,
    output logic        rom_sum_valid
`endif
);
    typedef enum logic [1:0] {IDLE, P1_WAIT, P2_WAIT, FLUSH} state_t;
    state_t      state_q, state_d;
    logic        lv_q, lv_d;
    logic [7:0]  lo_q, lo_d;
    logic [22:0] la_q, la_d;
    logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d;
    logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
    logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
    logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
    logic        dl_wr_q, dl_wr_d;
    logic [16:0] dl_addr_q, dl_addr_d;
    logic [7:0]  dl_data_q, dl_data_d;
    logic [63:0] dip_q, dip_d;
    logic        loaded_q, loaded_d, pend_q, pend_d, dl_prev_q;
    logic        acc, wr_rom, is_cpu, is_sp, is_bram, fell, done;
    logic [23:0] s;
    logic [22:0] wa;
    assign acc     = ioctl_wr && ioctl_download && state_q == IDLE;
    assign wr_rom  = acc && ioctl_index == 8'd0;
    assign is_cpu  = ioctl_addr <= CPU_END;
    assign is_sp   = ioctl_addr >= SP_BASE && ioctl_addr <= SP_END;
    assign is_bram = !is_cpu && !is_sp && ioctl_addr <= BRAM_END;
    assign s       = 24'(ioctl_addr - SP_BASE);
    assign wa      = ioctl_addr[23:1];
    assign fell    = dl_prev_q && !ioctl_download;
    // the end-of-ROM flag waits until any leftover odd byte has reached SDRAM
    assign done    = pend_q && state_q == IDLE && !lv_q;
    always_comb begin
        state_d   = state_q;
        lv_d      = lv_q;
        lo_d      = lo_q;
        la_d      = la_q;
        p1_req_d  = p1_req_q;
        p1_a_d    = p1_a_q;
        p1_ds_d   = p1_ds_q;
        p1_d_d    = p1_d_q;
        p2_req_d  = p2_req_q;
        p2_a_d    = p2_a_q;
        p2_ds_d   = p2_ds_q;
        p2_d_d    = p2_d_q;
        dl_wr_d   = 1'b0;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
        dip_d     = dip_q;
        case (state_q)
            IDLE: begin
                if (wr_rom && is_cpu) begin
                    if (!ioctl_addr[0]) begin
                        // an unmatched low byte is pushed out alone before the new one replaces it
                        if (lv_q) begin
                            p1_a_d   = la_q;
                            p1_d_d   = {lo_q, lo_q};
                            p1_ds_d  = 2'b01;
                            p1_req_d = !p1_req_q;
                            state_d  = P1_WAIT;
                        end
                        lv_d = 1'b1;
                        lo_d = ioctl_dout;
                        la_d = wa;
                    end else if (lv_q && la_q == wa) begin
                        p1_a_d   = wa;
                        p1_d_d   = {ioctl_dout, lo_q};
                        p1_ds_d  = 2'b11;
                        p1_req_d = !p1_req_q;
                        lv_d     = 1'b0;
                        state_d  = P1_WAIT;
                    end else begin
                        // lone high byte; any unrelated latched byte stays for a later flush
                        p1_a_d   = wa;
                        p1_d_d   = {ioctl_dout, ioctl_dout};
                        p1_ds_d  = 2'b10;
                        p1_req_d = !p1_req_q;
                        state_d  = P1_WAIT;
                    end
                end else if (wr_rom && is_sp) begin
                    p2_a_d   = {s[23:16], s[13:0], s[15]};
                    p2_ds_d  = {s[14], !s[14]};
                    p2_d_d   = {ioctl_dout, ioctl_dout};
                    p2_req_d = !p2_req_q;
                    state_d  = P2_WAIT;
                end else if (wr_rom && is_bram) begin
                    dl_wr_d   = 1'b1;
                    dl_addr_d = ioctl_addr[16:0];
                    dl_data_d = ioctl_dout;
                end else if (!ioctl_download && lv_q) begin
                    state_d = FLUSH;
                end
            end
            P1_WAIT: state_d = port1_ack == p1_req_q ? IDLE : P1_WAIT;
            P2_WAIT: state_d = port2_ack == p2_req_q ? IDLE : P2_WAIT;
            FLUSH: begin
                p1_a_d   = la_q;
                p1_d_d   = {lo_q, lo_q};
                p1_ds_d  = 2'b01;
                p1_req_d = !p1_req_q;
                lv_d     = 1'b0;
                state_d  = P1_WAIT;
            end
            default: state_d = IDLE;
        endcase
        if (acc && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
            dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end
    assign pend_d   = fell && ioctl_index == 8'd0 ? 1'b1 : done ? 1'b0 : pend_q;
    assign loaded_d = loaded_q || done;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lv_q      <= 1'b0;
            lo_q      <= 8'd0;
            la_q      <= 23'd0;
            p1_req_q  <= 1'b0;
            p1_a_q    <= 23'd0;
            p1_ds_q   <= 2'd0;
            p1_d_q    <= 16'd0;
            p2_req_q  <= 1'b0;
            p2_a_q    <= 23'd0;
            p2_ds_q   <= 2'd0;
            p2_d_q    <= 16'd0;
            dl_wr_q   <= 1'b0;
            dl_addr_q <= 17'd0;
            dl_data_q <= 8'd0;
            dip_q     <= 64'd0;
            loaded_q  <= 1'b0;
            pend_q    <= 1'b0;
            dl_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lv_q      <= lv_d;
            lo_q      <= lo_d;
            la_q      <= la_d;
            p1_req_q  <= p1_req_d;
            p1_a_q    <= p1_a_d;
            p1_ds_q   <= p1_ds_d;
            p1_d_q    <= p1_d_d;
            p2_req_q  <= p2_req_d;
            p2_a_q    <= p2_a_d;
            p2_ds_q   <= p2_ds_d;
            p2_d_q    <= p2_d_d;
            dl_wr_q   <= dl_wr_d;
            dl_addr_q <= dl_addr_d;
            dl_data_q <= dl_data_d;
            dip_q     <= dip_d;
            loaded_q  <= loaded_d;
            pend_q    <= pend_d;
            dl_prev_q <= ioctl_download;
        end
    end
    assign ioctl_wait = state_q != IDLE;
    assign port1_req  = p1_req_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign dl_wr      = dl_wr_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;
    assign dip_sw     = dip_q;
    assign rom_loaded = loaded_q;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        sumv_q, sumv_d;
    logic        rose;
    assign rose   = ioctl_download && !dl_prev_q;
    assign sum_d  = (rose ? 16'd0 : sum_q) + (wr_rom ? {8'd0, ioctl_dout} : 16'd0);
    assign sumv_d = rose ? 1'b0 : done ? 1'b1 : sumv_q;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sum_q  <= 16'd0;
            sumv_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            sumv_q <= sumv_d;
        end
    end
    assign rom_sum       = sum_q;
    assign rom_sum_valid = sumv_q;
`endif
endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: directed vector bench for rom_dl_router with a 4-cycle toggle-ack SDRAM model
module tb_rom_dl_router;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
    logic        ioctl_wait, port1_req, port1_ack, port2_req, port2_ack, dl_wr, rom_loaded;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic [63:0] dip_sw;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] rom_sum;
    logic        rom_sum_valid;
`endif
    rom_dl_router dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dip_sw(dip_sw), .rom_loaded(rom_loaded)
`ifdef ROM_DL_CHECKSUM_EN
        , .rom_sum(rom_sum), .rom_sum_valid(rom_sum_valid)
`endif
    );
    always #5 clk_sys = !clk_sys;
    // SDRAM model: ack follows a req toggle after four cycles of mismatch
    logic [2:0] c1, c2;
    always @(posedge clk_sys) begin
        if (!reset_n) begin
            port1_ack <= 1'b0;
            port2_ack <= 1'b0;
            c1 <= '0;
            c2 <= '0;
        end else begin
            if (port1_req != port1_ack) begin
                port1_ack <= c1 == 3'd3 ? !port1_ack : port1_ack;
                c1 <= c1 == 3'd3 ? 3'd0 : c1 + 3'd1;
            end
            if (port2_req != port2_ack) begin
                port2_ack <= c2 == 3'd3 ? !port2_ack : port2_ack;
                c2 <= c2 == 3'd3 ? 3'd0 : c2 + 3'd1;
            end
        end
    end
    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  d;
        int          kind;
        logic [22:0] ea;
        logic [15:0] ed;
        logic [1:0]  eds;
        logic [63:0] edip;
    } vec_t;
    int n_cmp = 0, n_fail = 0;
    logic [15:0] exp_sum = '0;
    function automatic vec_t mk(logic [7:0] i, logic [24:0] a, logic [7:0] d, int k, logic [22:0] ea,
                                logic [15:0] ed, logic [1:0] eds, logic [63:0] edip);
        vec_t v;
        v.idx = i; v.addr = a; v.d = d; v.kind = k; v.ea = ea; v.ed = ed; v.eds = eds; v.edip = edip;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask
    task automatic wr_byte(input logic [7:0] i, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = i; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask
    task automatic wait_cycles(output int n);
        n = 0;
        while (ioctl_wait && n < 20) begin
            n++;
            @(negedge clk_sys);
        end
    endtask
    // kind: 0 nothing routed, 1 port1 write, 2 port2 write, 3 block RAM write
    task automatic apply(input vec_t v, input string nm);
        logic r1, r2;
        int n;
        r1 = port1_req; r2 = port2_req;
        wr_byte(v.idx, v.addr, v.d);
        if (v.idx == 8'd0) exp_sum += {8'd0, v.d};
        chk({nm, ".p1req"}, port1_req ^ r1, v.kind == 1);
        chk({nm, ".p2req"}, port2_req ^ r2, v.kind == 2);
        chk({nm, ".dlwr"}, dl_wr, v.kind == 3);
        chk({nm, ".dip"}, dip_sw, v.edip);
        if (v.kind == 1) begin
            chk({nm, ".p1a"}, port1_a, v.ea);
            chk({nm, ".p1d"}, port1_d, v.ed);
            chk({nm, ".p1ds"}, port1_ds, v.eds);
        end
        if (v.kind == 2) begin
            chk({nm, ".p2a"}, port2_a, v.ea);
            chk({nm, ".p2d"}, port2_d, v.ed);
            chk({nm, ".p2ds"}, port2_ds, v.eds);
        end
        if (v.kind == 3) begin
            chk({nm, ".dladdr"}, dl_addr, v.ea[16:0]);
            chk({nm, ".dldata"}, dl_data, v.ed[7:0]);
        end
        wait_cycles(n);
        chk({nm, ".waitlen"}, n, (v.kind == 1 || v.kind == 2) ? 5 : 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        localparam logic [63:0] DP = 64'hA500_0000_0000_F000;
        vec_t tbl[21];
        logic r1, seen;
        int n;
        tbl[0]  = mk(254, 'h00001, 'hF0, 0, 0, 0, 0, 64'h0000_0000_0000_F000);
        tbl[1]  = mk(254, 'h00008, 'h5A, 0, 0, 0, 0, 64'h0000_0000_0000_F000);
        tbl[2]  = mk(254, 'h00007, 'hA5, 0, 0, 0, 0, DP);
        tbl[3]  = mk(0, 'h00000, 'h12, 0, 0, 0, 0, DP);
        tbl[4]  = mk(0, 'h00001, 'h34, 1, 'h0, 'h3412, 2'b11, DP);
        tbl[5]  = mk(0, 'h00003, 'h77, 1, 'h1, 'h7777, 2'b10, DP);
        tbl[6]  = mk(0, 'h00004, 'h11, 0, 0, 0, 0, DP);
        tbl[7]  = mk(0, 'h00006, 'h22, 1, 'h2, 'h1111, 2'b01, DP);
        tbl[8]  = mk(0, 'h00007, 'h33, 1, 'h3, 'h3322, 2'b11, DP);
        tbl[9]  = mk(0, 'h14001, 'h5A, 2, 'h2, 'h5A5A, 2'b10, DP);
        tbl[10] = mk(0, 'h10000, 'h01, 2, 'h0, 'h0101, 2'b01, DP);
        tbl[11] = mk(0, 'h18002, 'h9C, 2, 'h5, 'h9C9C, 2'b01, DP);
        tbl[12] = mk(0, 'h1BFFF, 'hEE, 2, 'h7FFF, 'hEEEE, 2'b01, DP);
        tbl[13] = mk(0, 'h1C005, 'hC3, 3, 'h1C005, 'h00C3, 0, DP);
        tbl[14] = mk(0, 'h0A000, 'h44, 3, 'h0A000, 'h0044, 0, DP);
        tbl[15] = mk(0, 'h0FFFF, 'h55, 3, 'h0FFFF, 'h0055, 0, DP);
        tbl[16] = mk(0, 'h1C000, 'h66, 3, 'h1C000, 'h0066, 0, DP);
        tbl[17] = mk(0, 'h1C31F, 'h77, 3, 'h1C31F, 'h0077, 0, DP);
        tbl[18] = mk(0, 'h1C320, 'h88, 0, 0, 0, 0, DP);
        tbl[19] = mk(0, 'h09FFF, 'h99, 1, 'h4FFF, 'h9999, 2'b10, DP);
        tbl[20] = mk(0, 'h00100, 'hAB, 0, 0, 0, 0, DP);
        repeat (3) @(negedge clk_sys);
        chk("rst.wait", ioctl_wait, 0);
        chk("rst.p1req", port1_req, 0);
        chk("rst.p2req", port2_req, 0);
        chk("rst.dlwr", dl_wr, 0);
        chk("rst.loaded", rom_loaded, 0);
        chk("rst.dip", dip_sw, 0);
        chk("rst.p1a", port1_a, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
        // write during back-pressure must be dropped
        r1 = port1_req;
        wr_byte(0, 'h00005, 'h5E);
        exp_sum += 16'h5E;
        chk("drop.p1req", port1_req ^ r1, 1);
        chk("drop.p1d", port1_d, 16'h5E5E);
        chk("drop.p1ds", port1_ds, 2'b10);
        chk("drop.wait", ioctl_wait, 1);
        wr_byte(0, 'h1C010, 'h3C);
        seen = dl_wr;
        n = 0;
        while (ioctl_wait && n < 20) begin
            n++;
            @(negedge clk_sys);
            seen |= dl_wr;
        end
        chk("drop.dlwr", seen, 0);
        chk("drop.dladdr", dl_addr, 17'h1C31F);
        chk("drop.loaded", rom_loaded, 0);
        // end of download with an odd byte still latched
        r1 = port1_req;
        ioctl_download = 1'b0;
        n = 0;
        while (port1_req == r1 && n < 20) begin
            n++;
            @(negedge clk_sys);
        end
        chk("flush.toggle", port1_req ^ r1, 1);
        chk("flush.p1a", port1_a, 23'h80);
        chk("flush.p1d", port1_d[7:0], 8'hAB);
        chk("flush.p1ds", port1_ds, 2'b01);
        chk("flush.early", rom_loaded, 0);
        n = 0;
        while (!rom_loaded && n < 20) begin
            n++;
            @(negedge clk_sys);
        end
        chk("flush.loaded", rom_loaded, 1);
        chk("flush.wait", ioctl_wait, 0);
`ifdef ROM_DL_CHECKSUM_EN
        chk("sum.value", rom_sum, exp_sum);
        chk("sum.valid", rom_sum_valid, 1);
`endif
        // reset while port1 write is outstanding
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        apply(mk(0, 'h00000, 'h11, 0, 0, 0, 0, DP), "rst.latch");
        wr_byte(0, 'h00005, 'h5E);
        chk("midrst.waitpre", ioctl_wait, 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("midrst.wait", ioctl_wait, 0);
        chk("midrst.loaded", rom_loaded, 0);
        chk("midrst.dip", dip_sw, 0);
        chk("midrst.p1req", port1_req, 0);
        chk("midrst.p1d", port1_d, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        apply(mk(0, 'h00001, 'h22, 1, 'h0, 'h2222, 2'b10, 0), "midrst.single");
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("midrst.reload", rom_loaded, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
